mtimer: RTL and testbench
=========================

# mtimer

Machine-timer peripheral and source of the core's machine timer interrupt. It holds a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, both memory-mapped on the load/store data bus. It drives a level interrupt into the CSR unit's `interrupt` input, which feeds `mip.MTIP`. Software clears the interrupt by rewriting `mtimecmp`.

## Interface
- `BASE_ADDR`, default 32'h0200_0000: byte base of the register window.
- `PRESCALE_W`, default 8: width of the prescaler divide field.
- `clk` input 1: core clock; all state updates on posedge.
- `rst` input 1: reset, asynchronous and active-low.
- `tmr_addr` input 32: byte address from the LSU.
- `tmr_wdata` input 32: store data.
- `tmr_wr` input 1: store strobe, one cycle per access.
- `tmr_rd` input 1: load strobe, one cycle per access.
- `tmr_rdata` output 32: load data; combinational from the registers.
- `tmr_hit` output 1: `tmr_addr` lies in `[BASE_ADDR, BASE_ADDR+0x14)` and is word-aligned.
- `timer_irq` output 1: registered level interrupt, connected to CSR `interrupt`.

## Operation
- Register map (byte offsets):
  - 0x00 `MTIME_LO`
  - 0x04 `MTIME_HI`
  - 0x08 `MTIMECMP_LO`
  - 0x0C `MTIMECMP_HI`
  - 0x10 `CTRL`: bit0 `EN`; bits[8+PRESCALE_W-1:8] `DIV`; all other bits read 0.
- Accesses with `tmr_hit`=0 are ignored and `tmr_rdata`=0. Misaligned addresses produce a miss.
- Prescaler:
  - `pcnt` (PRESCALE_W bits) counts only while `EN`=1.
  - When `pcnt == DIV`, set `pcnt` to 0 and increment `mtime` by 1. Otherwise increment `pcnt`.
  - `DIV`=0 means `mtime` increments every cycle.
  - Writing `CTRL` clears `pcnt`. `EN`=0 freezes both `pcnt` and `mtime`.
- `mtime` is 64-bit and wraps from all-ones to 0 with no flag.
- Atomic 64-bit read:
  - A load of `MTIME_LO` returns the live low word and, on the same edge, captures the live high word into `hi_shadow`.
  - A load of `MTIME_HI` returns `hi_shadow`.
  - `hi_shadow` reset value is 0.
- Write to `MTIME_LO`/`MTIME_HI` replaces that half. A software write in the same cycle as a tick has priority; the tick is lost and no carry occurs.
- Writes to `MTIMECMP_*` replace the addressed half only.
- A simultaneous `tmr_rd` and `tmr_wr` is illegal and is treated as a write only.
- Interrupt:
  - `timer_irq` is registered: next value is `EN & (mtime >= mtimecmp)`, an unsigned 64-bit comparison against the current registers.
  - The level stays asserted until `mtimecmp` is raised above `mtime` or `EN` is cleared. There is no latch or acknowledge.

## Timing
- Reset values:
  - `mtime` = 0
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF
  - `CTRL` = 0 (disabled)
  - `pcnt` = 0
  - `timer_irq` = 0
- `tmr_rdata` and `tmr_hit` are combinational and depend only on address and state. With reset asserted, `tmr_rdata` returns the reset register values.
- Write latency: a register written at edge N holds the new value from N onward and affects `timer_irq` at edge N+1.
- Compare latency: if `mtime` becomes ≥ `mtimecmp` at edge N, `timer_irq` rises at edge N+1. The CSR samples it on the following negedge.
- Deassertion after a `mtimecmp` write at edge N: `timer_irq` falls at edge N+1.
- Reset asserted mid-count or mid-interrupt: all state is cleared immediately. The handler must not observe a glitch, because `timer_irq` is driven from a flop that is asynchronously cleared.
- Wrap: `mtime` = all-ones plus one tick gives 0. If `mtimecmp` = 0 the interrupt stays asserted, since 0 ≥ 0.

## Test plan
- Reset check: after `rst` deasserts, read all five registers.
  - Required: 0, 0, FFFF_FFFF, FFFF_FFFF, 0; `timer_irq`=0 for 100 cycles.
- Basic fire: write `MTIMECMP_HI`=0, `MTIMECMP_LO`=10, then `CTRL`=1 (enable, `DIV`=0) at edge N.
  - Required: `mtime` reaches 10 at N+10; `timer_irq`=1 at N+11 and remains 1.
  - Then write `MTIMECMP_LO`=100 at edge M. Required: `timer_irq`=0 at M+1.
- Prescale: `CTRL`=0x0301 (`DIV`=3).
  - Required: `mtime` increments once every 4 cycles; after 40 cycles `mtime`=10.
  - Then write `CTRL`=0. Required: `mtime` is frozen.
- Atomic read across carry: write `MTIME_HI`=0, `MTIME_LO`=FFFF_FFFE, enable with `DIV`=0. Read LO in the cycle `mtime`=FFFF_FFFF, then read HI two cycles later.
  - Required: LO returns FFFF_FFFF, HI returns 0 (the shadow value, not 1).
- Write/tick collision: with `DIV`=0, write `MTIME_LO`=5 during an active tick.
  - Required: LO=5 after the edge and 6 one cycle later.
- Wrap and async reset: set `mtime`=all-ones and `mtimecmp`=0, enable.
  - Required: `mtime` wraps to 0 and `timer_irq` stays 1.
  - Then pull `rst` low mid-cycle. Required: `timer_irq`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mtimer.sv
// Machine timer: free-running 64-bit mtime with prescaler, 64-bit mtimecmp and a registered
// level interrupt, all exposed as a small word-addressed register window on the LSU bus.
module mtimer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tmr_addr,
    input  logic [31:0] tmr_wdata,
    input  logic        tmr_wr,
    input  logic        tmr_rd,
    output logic [31:0] tmr_rdata,
    output logic        tmr_hit,
    output logic        timer_irq
);

    typedef enum logic [2:0] {
        RegMtimeLo = 3'd0,
        RegMtimeHi = 3'd1,
        RegCmpLo   = 3'd2,
        RegCmpHi   = 3'd3,
        RegCtrl    = 3'd4
    } reg_e;

    logic [31:0]           offset;
    reg_e                  reg_idx;
    logic                  wr_en;
    logic                  rd_en;
    logic                  tick;
    logic [31:0]           ctrl_rdata;

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           cmp_q, cmp_d;
    logic                  en_q, en_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           shadow_q, shadow_d;
    logic                  irq_q, irq_d;

    // Subtracting first keeps the range test correct even if the window sits at the top of memory.
    assign offset  = tmr_addr - BASE_ADDR;
    assign tmr_hit = (tmr_addr >= BASE_ADDR) && (offset < 32'h14) && (offset[1:0] == 2'b00);
    assign reg_idx = reg_e'(offset[4:2]);

    // A simultaneous load and store is handled as a store only.
    assign wr_en = tmr_wr && tmr_hit;
    assign rd_en = tmr_rd && tmr_hit && !tmr_wr;

    assign tick = en_q && (pcnt_q == div_q);

    always_comb begin
        mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
        pcnt_d   = pcnt_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        irq_d    = en_q && (mtime_q >= cmp_q);

        if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        end

        if (wr_en) begin
            // Software writes to mtime override a coincident tick, so no carry propagates.
            case (reg_idx)
                RegMtimeLo: mtime_d = {mtime_q[63:32], tmr_wdata};
                RegMtimeHi: mtime_d = {tmr_wdata, mtime_q[31:0]};
                RegCmpLo:   cmp_d   = {cmp_q[63:32], tmr_wdata};
                RegCmpHi:   cmp_d   = {tmr_wdata, cmp_q[31:0]};
                RegCtrl: begin
                    en_d   = tmr_wdata[0];
                    div_d  = tmr_wdata[8 +: PRESCALE_W];
                    pcnt_d = '0;
                end
                default: ;
            endcase
        end else if (rd_en && (reg_idx == RegMtimeLo)) begin
            // Freeze the high word alongside the low-word read for a tear-free 64-bit read.
            shadow_d = mtime_q[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q  <= '0;
            cmp_q    <= '1;
            en_q     <= 1'b0;
            div_q    <= '0;
            pcnt_q   <= '0;
            shadow_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            div_q    <= div_d;
            pcnt_q   <= pcnt_d;
            shadow_q <= shadow_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        ctrl_rdata                   = '0;
        ctrl_rdata[0]                = en_q;
        ctrl_rdata[8 +: PRESCALE_W]  = div_q;
        tmr_rdata                    = '0;
        if (tmr_hit) begin
            case (reg_idx)
                RegMtimeLo: tmr_rdata = mtime_q[31:0];
                RegMtimeHi: tmr_rdata = shadow_q;
                RegCmpLo:   tmr_rdata = cmp_q[31:0];
                RegCmpHi:   tmr_rdata = cmp_q[63:32];
                RegCtrl:    tmr_rdata = ctrl_rdata;
                default:    tmr_rdata = '0;
            endcase
        end
    end

    assign timer_irq = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: register-access vector table, hand-written timing sequences
// and randomized bus traffic compared against a cycle-level behavioural model.
module tb_mtimer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tmr_addr = BASE;
    logic [31:0] tmr_wdata = '0;
    logic        tmr_wr = 1'b0;
    logic        tmr_rd = 1'b0;
    logic [31:0] tmr_rdata;
    logic        tmr_hit;
    logic        timer_irq;

    always #5 clk = ~clk;

    mtimer #(
        .BASE_ADDR (BASE),
        .PRESCALE_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tmr_addr (tmr_addr),
        .tmr_wdata(tmr_wdata),
        .tmr_wr   (tmr_wr),
        .tmr_rd   (tmr_rd),
        .tmr_rdata(tmr_rdata),
        .tmr_hit  (tmr_hit),
        .timer_irq(timer_irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Behavioural model: m_cnt counts enabled cycles since the last CTRL write; a tick happens
    // whenever that count completes a period of DIV+1 cycles.
    logic [63:0] m_time, m_cmp;
    logic        m_en;
    logic [7:0]  m_div;
    int          m_cnt;
    logic [31:0] m_shadow;
    logic        m_irq;

    function automatic void m_reset();
        m_time   = '0;
        m_cmp    = '1;
        m_en     = 1'b0;
        m_div    = '0;
        m_cnt    = 0;
        m_shadow = '0;
        m_irq    = 1'b0;
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && (off < 20) && (off % 4 == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!m_hit(a)) return 32'd0;
        case (off)
            0:       return m_time[31:0];
            4:       return m_shadow;
            8:       return m_cmp[31:0];
            12:      return m_cmp[63:32];
            default: return {16'd0, m_div, 7'd0, m_en};
        endcase
    endfunction

    task automatic apply(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        tmr_wr    = w;
        tmr_rd    = r;
        tmr_addr  = a;
        tmr_wdata = d;
        #1;
        check("hit", tmr_hit, m_hit(a));
        check("rdata", tmr_rdata, m_read(a));
    endtask

    task automatic clock_edge();
        logic [31:0] off;
        logic        w, r, tick, n_en, n_irq;
        logic [63:0] n_time, n_cmp;
        logic [7:0]  n_div;
        logic [31:0] n_shadow;
        int          n_cnt;
        off      = tmr_addr - BASE;
        w        = tmr_wr && m_hit(tmr_addr);
        r        = tmr_rd && m_hit(tmr_addr) && !tmr_wr;
        tick     = m_en && (m_cnt % (int'(m_div) + 1) == int'(m_div));
        n_irq    = m_en && (m_time >= m_cmp);
        n_time   = tick ? m_time + 64'd1 : m_time;
        n_cnt    = m_en ? m_cnt + 1 : m_cnt;
        n_cmp    = m_cmp;
        n_en     = m_en;
        n_div    = m_div;
        n_shadow = m_shadow;
        if (w) begin
            case (off)
                0:  n_time = {m_time[63:32], tmr_wdata};
                4:  n_time = {tmr_wdata, m_time[31:0]};
                8:  n_cmp  = {m_cmp[63:32], tmr_wdata};
                12: n_cmp  = {tmr_wdata, m_cmp[31:0]};
                16: begin
                    n_en  = tmr_wdata[0];
                    n_div = tmr_wdata[15:8];
                    n_cnt = 0;
                end
                default: ;
            endcase
        end else if (r && off == 0) begin
            n_shadow = m_time[63:32];
        end
        @(posedge clk);
        #1;
        m_time   = n_time;
        m_cmp    = n_cmp;
        m_en     = n_en;
        m_div    = n_div;
        m_cnt    = n_cnt;
        m_shadow = n_shadow;
        m_irq    = n_irq;
        check("irq", timer_irq, m_irq);
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        apply(w, r, a, d);
        clock_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, BASE, 32'd0);
    endtask

    task automatic do_reset();
        tmr_wr    = 1'b0;
        tmr_rd    = 1'b0;
        tmr_addr  = BASE;
        tmr_wdata = '0;
        rst       = 1'b0;
        m_reset();
        #1;
        check("irq_in_reset", timer_irq, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] off;
        logic [31:0] d;
        logic        hit;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Register-access vectors with the timer disabled; rdata is the value before the edge.
        tbl.push_back('{1'b0, 1'b1, 32'h00, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 32'hFFFF_FFFF});
        tbl.push_back('{1'b0, 1'b1, 32'h0C, 32'h0, 1'b1, 32'hFFFF_FFFF});
        tbl.push_back('{1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h14, 32'h0, 1'b0, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h02, 32'h0, 1'b0, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0000_0000});
        tbl.push_back('{1'b1, 1'b0, 32'h10, 32'h0000_0300, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000_0300});
        tbl.push_back('{1'b1, 1'b0, 32'h10, 32'hFFFF_FFFE, 1'b1, 32'h0000_0300});
        tbl.push_back('{1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000_FF00});
        tbl.push_back('{1'b1, 1'b0, 32'h08, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 32'h1234_5678});
        tbl.push_back('{1'b0, 1'b1, 32'h0C, 32'h0, 1'b1, 32'hFFFF_FFFF});
        tbl.push_back('{1'b1, 1'b0, 32'h04, 32'h0000_00A5, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h00, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h0000_00A5});
        tbl.push_back('{1'b1, 1'b0, 32'h04, 32'h0000_00B6, 1'b1, 32'h0000_00A5});
        tbl.push_back('{1'b1, 1'b1, 32'h00, 32'h0000_0007, 1'b1, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h0000_00A5});
        tbl.push_back('{1'b0, 1'b1, 32'h00, 32'h0, 1'b1, 32'h0000_0007});
        tbl.push_back('{1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h0000_00B6});
        tbl.push_back('{1'b1, 1'b0, 32'h14, 32'h0000_DEAD, 1'b0, 32'h0000_0000});
        tbl.push_back('{1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000_FF00});
        tbl.push_back('{1'b1, 1'b0, 32'h10, 32'h0000_0000, 1'b1, 32'h0000_FF00});

        // Reset state and quiet interrupt.
        do_reset();
        idle(100);

        foreach (tbl[i]) begin
            apply(tbl[i].w, tbl[i].r, BASE + tbl[i].off, tbl[i].d);
            check($sformatf("tbl%0d_hit", i), tmr_hit, tbl[i].hit);
            check($sformatf("tbl%0d_rdata", i), tmr_rdata, tbl[i].rdata);
            clock_edge();
        end

        // Basic fire and deassertion by raising mtimecmp.
        do_reset();
        step(1'b1, 1'b0, BASE + 12, 32'd0);
        step(1'b1, 1'b0, BASE + 8, 32'd10);
        step(1'b1, 1'b0, BASE + 16, 32'd1);
        idle(10);
        apply(1'b0, 1'b0, BASE, 32'd0);
        check("fire_mtime_10", tmr_rdata, 32'd10);
        check("fire_irq_before", timer_irq, 1'b0);
        clock_edge();
        check("fire_irq_rise", timer_irq, 1'b1);
        idle(5);
        check("fire_irq_hold", timer_irq, 1'b1);
        step(1'b1, 1'b0, BASE + 8, 32'd100);
        check("fire_irq_at_write", timer_irq, 1'b1);
        idle(1);
        check("fire_irq_fall", timer_irq, 1'b0);

        // Prescaler DIV=3 then freeze.
        do_reset();
        step(1'b1, 1'b0, BASE + 16, 32'h0000_0301);
        idle(40);
        apply(1'b0, 1'b0, BASE, 32'd0);
        check("pre_mtime_10", tmr_rdata, 32'd10);
        clock_edge();
        step(1'b1, 1'b0, BASE + 16, 32'd0);
        idle(8);
        apply(1'b0, 1'b0, BASE, 32'd0);
        check("pre_frozen", tmr_rdata, 32'd10);
        clock_edge();

        // Atomic 64-bit read across the low-word carry.
        do_reset();
        step(1'b1, 1'b0, BASE + 4, 32'd0);
        step(1'b1, 1'b0, BASE, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, BASE + 16, 32'd1);
        idle(1);
        apply(1'b0, 1'b1, BASE, 32'd0);
        check("atomic_lo", tmr_rdata, 32'hFFFF_FFFF);
        clock_edge();
        idle(1);
        apply(1'b0, 1'b1, BASE + 4, 32'd0);
        check("atomic_hi_shadow", tmr_rdata, 32'd0);
        clock_edge();
        step(1'b0, 1'b1, BASE, 32'd0);
        apply(1'b0, 1'b1, BASE + 4, 32'd0);
        check("atomic_hi_after_carry", tmr_rdata, 32'd1);
        clock_edge();

        // Software write colliding with a tick.
        do_reset();
        step(1'b1, 1'b0, BASE + 16, 32'd1);
        idle(3);
        step(1'b1, 1'b0, BASE, 32'd5);
        apply(1'b0, 1'b0, BASE, 32'd0);
        check("collide_lo_5", tmr_rdata, 32'd5);
        clock_edge();
        apply(1'b0, 1'b0, BASE, 32'd0);
        check("collide_lo_6", tmr_rdata, 32'd6);
        clock_edge();

        // Wrap with mtimecmp=0, then asynchronous reset mid-cycle.
        do_reset();
        step(1'b1, 1'b0, BASE + 8, 32'd0);
        step(1'b1, 1'b0, BASE + 12, 32'd0);
        step(1'b1, 1'b0, BASE, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, BASE + 4, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, BASE + 16, 32'd1);
        clock_edge();
        check("wrap_irq_rise", timer_irq, 1'b1);
        apply(1'b0, 1'b1, BASE, 32'd0);
        check("wrap_lo_0", tmr_rdata, 32'd0);
        clock_edge();
        apply(1'b0, 1'b1, BASE + 4, 32'd0);
        check("wrap_hi_0", tmr_rdata, 32'd0);
        clock_edge();
        idle(3);
        check("wrap_irq_hold", timer_irq, 1'b1);
        tmr_addr = BASE + 8;
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        check("async_irq_clear", timer_irq, 1'b0);
        check("async_cmp_reset", tmr_rdata, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic        w, r;
            logic [31:0] a, d;
            int          sel;
            sel = $urandom_range(0, 99);
            w   = (sel < 30) || (sel >= 95);
            r   = (sel >= 30 && sel < 60) || (sel >= 95);
            a   = BASE + 32'($urandom_range(0, 5) * 4);
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 40));
            step(w, r, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
